// File: rtl/msg_seq_pkg.sv
// Shared types and message ROM contents for the ASCII character sequencer.
package msg_seq_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, NL} seq_state_t;

  localparam int ROM_MSGS = 4;
  localparam int ROM_LEN  = 16;

  localparam logic [7:0] NL_CHAR = 8'h0A;

  localparam int MSG_LEN [ROM_MSGS] = '{9, 7, 6, 3};

  // "Guatemala", "Quetzal", "Zacapa", "Soy", zero padded to ROM_LEN
  localparam logic [7:0] ROM_INIT [ROM_MSGS][ROM_LEN] = '{
    '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C,
      8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h5A, 8'h61, 8'h63, 8'h61, 8'h70, 8'h61, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h53, 8'h6F, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  function automatic int msg_len(input int m);
    if (m >= 0 && m < ROM_MSGS) return MSG_LEN[m];
    return 1;
  endfunction

  function automatic logic [7:0] rom_char(input int m, input int i);
    if (m >= 0 && m < ROM_MSGS && i >= 0 && i < ROM_LEN) return ROM_INIT[m][i];
    return 8'h00;
  endfunction

endpackage

// File: rtl/msg_rom.sv
// Synchronous-read message ROM, one-cycle latency, addressed as {msg, index}.
module msg_rom
  import msg_seq_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int MAX_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 2,
  parameter int IDX_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_en,
  input  logic [SEL_W+IDX_W-1:0]  addr,
  output logic [DATA_W-1:0]       rd_data
);

  int m;
  int i;
  logic [DATA_W-1:0] word;

  always_comb begin
    m = int'(addr[SEL_W+IDX_W-1:IDX_W]);
    i = int'(addr[IDX_W-1:0]);
    word = '0;
    if (m < NUM_MSG && i < MAX_LEN) word = DATA_W'(rom_char(m, i));
  end

  // Output register is cleared on reset so char_data reads 0 out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= word;
  end

endmodule

// File: rtl/msg_char_sequencer.sv
// Multi-message ASCII streamer over a valid/ready byte interface.
// Define SEQ_NEWLINE_EN to append an 8'h0A terminator to every message.
module msg_char_sequencer
  import msg_seq_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int MAX_LEN = 16,
  parameter int DATA_W  = 8,
  localparam int SEL_W  = $clog2(NUM_MSG),
  localparam int IDX_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              char_first,
  output logic              char_last,
  output logic              busy,
  output logic              done
);

  seq_state_t state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n, idx_last;
  logic [SEL_W-1:0] msg_q, msg_n, sel_eff;
  logic done_q, done_n, boundary;
  logic [DATA_W-1:0] rom_data;

  assign sel_eff  = (32'(sel) >= NUM_MSG) ? '0 : sel;
  assign idx_last = IDX_W'(msg_len(int'(msg_q)) - 1);

  msg_rom #(
    .NUM_MSG (NUM_MSG),
    .MAX_LEN (MAX_LEN),
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W),
    .IDX_W   (IDX_W)
  ) u_rom (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (state_q == FETCH),
    .addr    ({msg_q, idx_q}),
    .rd_data (rom_data)
  );

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    msg_n    = msg_q;
    done_n   = 1'b0;
    boundary = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          msg_n   = sel_eff;
          idx_n   = '0;
          state_n = FETCH;
        end
      end
      FETCH: state_n = SEND;
      SEND: begin
        if (char_ready) begin
          if (idx_q != idx_last) begin
            idx_n   = idx_q + IDX_W'(1);
            state_n = FETCH;
          end else begin
`ifdef SEQ_NEWLINE_EN
            state_n = NL;
`else
            boundary = 1'b1;
`endif
          end
        end
      end
      NL: begin
        if (char_ready) boundary = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Message boundary: sel is re-sampled only here when looping
    if (boundary) begin
      if (loop_mode && !stop) begin
        msg_n   = sel_eff;
        idx_n   = '0;
        state_n = FETCH;
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      msg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      msg_q   <= msg_n;
      done_q  <= done_n;
    end
  end

  assign char_valid = (state_q == SEND) || (state_q == NL);
  assign char_data  = (state_q == NL) ? DATA_W'(NL_CHAR) : rom_data;
  assign char_first = (state_q == SEND) && (idx_q == '0);
`ifdef SEQ_NEWLINE_EN
  assign char_last  = (state_q == NL);
`else
  assign char_last  = (state_q == SEND) && (idx_q == idx_last);
`endif
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_msg_char_sequencer.sv
// Directed self-checking bench for msg_char_sequencer (default and NUM_MSG=3 builds).
module tb_msg_char_sequencer;

  logic clk = 1'b0;
  logic reset, start, stop, loop_mode, char_ready;
  logic [1:0] sel;
  logic [7:0] char_data;
  logic char_valid, char_first, char_last, busy, done;

  logic start3;
  logic [1:0] sel3;
  logic [7:0] data3;
  logic valid3, first3, last3, busy3, done3;

  int compared = 0;
  int mismatched = 0;
  string msgs [4];

  always #5 clk = ~clk;

  msg_char_sequencer #(.NUM_MSG(4), .MAX_LEN(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_mode(loop_mode),
    .sel(sel), .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .char_first(char_first), .char_last(char_last), .busy(busy), .done(done)
  );

  msg_char_sequencer #(.NUM_MSG(3), .MAX_LEN(16), .DATA_W(8)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .stop(stop), .loop_mode(loop_mode),
    .sel(sel3), .char_data(data3), .char_valid(valid3), .char_ready(char_ready),
    .char_first(first3), .char_last(last3), .busy(busy3), .done(done3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic lp,
                               input logic [1:0] s, input logic rdy);
    start = st; stop = sp; loop_mode = lp; sel = s; char_ready = rdy;
  endtask

  task automatic pulseStart(input logic [1:0] s);
    start = 1'b1; sel = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for a handshake, checks the byte, then steps past the accepting edge
  task automatic expectByte(input string tag, input logic [7:0] d, input logic f,
                            input logic l, input int gap);
    int waited = 0;
    while (!(char_valid && char_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " handshake"}, 32'(char_valid && char_ready), 32'd1);
    checkOutput({tag, " data"}, 32'(char_data), 32'(d));
    checkOutput({tag, " first"}, 32'(char_first), 32'(f));
    checkOutput({tag, " last"}, 32'(char_last), 32'(l));
    if (gap >= 0) checkOutput({tag, " gap"}, 32'(waited), 32'(gap));
    @(negedge clk);
  endtask

  task automatic expectRange(input int m, input int from, input int upto, input int gap);
    int len;
    logic lastFlag;
    len = msgs[m].len();
    for (int i = from; i < upto; i++) begin
`ifdef SEQ_NEWLINE_EN
      lastFlag = 1'b0;
`else
      lastFlag = (i == len - 1);
`endif
      expectByte($sformatf("msg%0d[%0d]", m, i), msgs[m][i], i == 0, lastFlag, gap);
    end
`ifdef SEQ_NEWLINE_EN
    if (upto == len) expectByte($sformatf("msg%0d nl", m), 8'h0A, 1'b0, 1'b1, 0);
`endif
  endtask

  task automatic checkDone(input string tag);
    checkOutput({tag, " done pulse"}, 32'(done), 32'd1);
    checkOutput({tag, " busy low"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, " done cleared"}, 32'(done), 32'd0);
  endtask

  initial begin
    int waited;
    msgs[0] = "Guatemala";
    msgs[1] = "Quetzal";
    msgs[2] = "Zacapa";
    msgs[3] = "Soy";
    reset = 1'b1;
    start3 = 1'b0;
    sel3 = 2'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset valid", 32'(char_valid), 32'd0);
    checkOutput("reset data", 32'(char_data), 32'd0);
    checkOutput("reset first", 32'(char_first), 32'd0);
    checkOutput("reset last", 32'(char_last), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] one-shot Guatemala");
    pulseStart(2'd0);
    expectRange(0, 0, 9, 1);
    checkDone("guatemala");

    $display("[TB] loop with backpressure, sel change and stop");
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    pulseStart(2'd1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d valid", k), 32'(char_valid), 32'd1);
      checkOutput($sformatf("stall%0d data", k), 32'(char_data), 32'h51);
      @(negedge clk);
    end
    char_ready = 1'b1;
    expectRange(1, 0, 1, 0);
    sel = 2'd2;
    expectRange(1, 1, 7, 1);
    stop = 1'b1;
    expectRange(2, 0, 6, 1);
    checkDone("loop stop");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    $display("[TB] one-shot Soy");
    pulseStart(2'd3);
    expectRange(3, 0, 3, 1);
    checkDone("soy");

    $display("[TB] start while busy");
    pulseStart(2'd0);
    expectRange(0, 0, 3, 1);
    start = 1'b1; sel = 2'd1;
    @(negedge clk);
    start = 1'b0;
    expectRange(0, 3, 4, 0);
    expectRange(0, 4, 9, 1);
    checkDone("busy start");

    $display("[TB] reset mid-Zacapa");
    pulseStart(2'd2);
    expectRange(2, 0, 2, 1);
    @(negedge clk);
    checkOutput("mid valid", 32'(char_valid), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst valid", 32'(char_valid), 32'd0);
    checkOutput("rst data", 32'(char_data), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post rst%0d done", k), 32'(done), 32'd0);
    end
    pulseStart(2'd2);
    expectRange(2, 0, 6, 1);
    checkDone("restart");

    $display("[TB] out-of-range sel on NUM_MSG=3 build");
    sel3 = 2'd3;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    waited = 0;
    while (!valid3 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("oor valid", 32'(valid3), 32'd1);
    checkOutput("oor data", 32'(data3), 32'h47);
    checkOutput("oor first", 32'(first3), 32'd1);
    waited = 0;
    while (!done3 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("oor done", 32'(done3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
